mynios2_onchip_ram_dp: RTL and testbench

Parametrised on-chip RAM for the Nios II system. It exposes two Avalon-MM slave ports (s1, s2) that share one inferred storage array. A round-robin arbiter serialises access, and each port has pipelined reads with readdatavalid and waitrequest. It replaces the fixed 32x1000 single-port memory wherever a second master (DMA, debug) needs the same RAM.

---
 rtl/mynios2_onchip_ram_dp.sv | 257 +++++++++++++++++++++++++
 tb/tb_mynios2_onchip_ram_dp.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mynios2_onchip_ram_dp.sv
// mynios2_onchip_ram_dp
//   Dual-port on-chip RAM for the Nios II system. Two Avalon-MM slave ports
//   (s1, s2) share one inferred storage array. A round-robin arbiter grants at
//   most one port per cycle. Reads are pipelined with readdatavalid, and
//   contention is signalled through waitrequest.
//
//   Parameters
//     DATA_WIDTH  word width in bits (multiple of 8)
//     DEPTH       number of words (need not be a power of two)
//     ADDR_WIDTH  word-address width, 2**ADDR_WIDTH >= DEPTH
//     INIT_FILE   hex image bound to the array by the vendor memory-init flow;
//                 "" means contents start at 0
//
//   Ports (sx = s1 or s2)
//     clk, reset_n          rising-edge clock, asynchronous active-low reset
//     sx_address            word address
//     sx_byteenable         byte lanes written
//     sx_chipselect         port select
//     sx_read / sx_write    requests; read+write together is treated as a write
//     sx_writedata          write data
//     sx_readdata           read data, held while sx_readdatavalid is low
//     sx_readdatavalid      one pulse per accepted read
//     sx_waitrequest        request present but not granted this cycle
//
//   Build option
//     MYNIOS2_ONCHIP_RAM_OUTREG_EN  adds an output register per port and makes
//                                   the read latency 2 cycles instead of 1.

module mynios2_onchip_ram_dp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1000,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter string       INIT_FILE  = "onchip_memory2.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,

  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_data_width
    $error("mynios2_onchip_ram_dp: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if ((64'd1 << ADDR_WIDTH) < 64'(DEPTH)) begin : g_bad_addr_width
    $error("mynios2_onchip_ram_dp: ADDR_WIDTH too narrow for DEPTH");
  end
  if (INIT_FILE != "") begin : g_init_image
    // The image is attached to mem by the vendor memory-init flow; no logic
    // is generated here.
  end

  // ---------------------------------------------------------------------
  // Request decode and round-robin arbitration
  // ---------------------------------------------------------------------
  typedef enum logic {
    PRI_S1 = 1'b0,
    PRI_S2 = 1'b1
  } pri_t;

  pri_t pri_q, pri_d;
  logic req1, req2;
  logic grant1, grant2;

  // Requests are masked during reset so nothing reaches the array and both
  // ports report waitrequest.
  assign req1 = reset_n & s1_chipselect & (s1_read | s1_write);
  assign req2 = reset_n & s2_chipselect & (s2_read | s2_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pri_q <= PRI_S1;
    end else begin
      pri_q <= pri_d;
    end
  end

  always_comb begin
    pri_d  = pri_q;
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (req1 && req2) begin
      // Contested cycle: serve the pointed-to port and hand priority over.
      if (pri_q == PRI_S1) begin
        grant1 = 1'b1;
        pri_d  = PRI_S2;
      end else begin
        grant2 = 1'b1;
        pri_d  = PRI_S1;
      end
    end else begin
      grant1 = req1;
      grant2 = req2;
    end
  end

  assign s1_waitrequest = ~reset_n | (req1 & ~grant1);
  assign s2_waitrequest = ~reset_n | (req2 & ~grant2);

  // ---------------------------------------------------------------------
  // Access mux into the single array port
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [NB-1:0]         acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_we;
  logic                  acc_re;
  logic                  acc_in_range;
  logic [IDX_W-1:0]      acc_idx;
  logic                  rd1_acc;
  logic                  rd2_acc;

  // A request with both read and write set is a write only.
  assign rd1_acc = grant1 & s1_read & ~s1_write;
  assign rd2_acc = grant2 & s2_read & ~s2_write;

  always_comb begin
    acc_addr  = s1_address;
    acc_be    = s1_byteenable;
    acc_wdata = s1_writedata;
    if (grant2) begin
      acc_addr  = s2_address;
      acc_be    = s2_byteenable;
      acc_wdata = s2_writedata;
    end
  end

  assign acc_we       = (grant1 & s1_write) | (grant2 & s2_write);
  assign acc_re       = rd1_acc | rd2_acc;
  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_LIM);
  assign acc_idx      = acc_addr[IDX_W-1:0];

  // ---------------------------------------------------------------------
  // Storage array: no reset, so it maps onto block RAM
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_ff @(posedge clk) begin
    if (acc_we && acc_in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
        end
      end
    end
    if (acc_re && acc_in_range) begin
      mem_rdata <= mem[acc_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Read-return tracking: one valid flag per port plus an out-of-range flag.
  // Zeroing out-of-range reads after the RAM register keeps the array
  // output path free of logic.
  // ---------------------------------------------------------------------
  logic                  rv1_q;
  logic                  rv2_q;
  logic                  rzero_q;
  logic [DATA_WIDTH-1:0] rdata_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv1_q   <= 1'b0;
      rv2_q   <= 1'b0;
      rzero_q <= 1'b0;
    end else begin
      rv1_q <= rd1_acc;
      rv2_q <= rd2_acc;
      if (acc_re) begin
        rzero_q <= ~acc_in_range;
      end
    end
  end

  assign rdata_s = rzero_q ? '0 : mem_rdata;

`ifdef MYNIOS2_ONCHIP_RAM_OUTREG_EN
  // Output register per port: data and valid travel together, giving a
  // read latency of 2 while still accepting one read per cycle.
  logic [DATA_WIDTH-1:0] out1_q;
  logic [DATA_WIDTH-1:0] out2_q;
  logic                  ov1_q;
  logic                  ov2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out1_q <= '0;
      out2_q <= '0;
      ov1_q  <= 1'b0;
      ov2_q  <= 1'b0;
    end else begin
      ov1_q <= rv1_q;
      ov2_q <= rv2_q;
      if (rv1_q) begin
        out1_q <= rdata_s;
      end
      if (rv2_q) begin
        out2_q <= rdata_s;
      end
    end
  end

  assign s1_readdata      = out1_q;
  assign s2_readdata      = out2_q;
  assign s1_readdatavalid = ov1_q;
  assign s2_readdatavalid = ov2_q;
`else
  // The shared RAM register is overwritten by the other port's reads, so
  // each port keeps a copy of its last returned word to hold readdata
  // steady between valids without adding a cycle of latency.
  logic [DATA_WIDTH-1:0] hold1_q;
  logic [DATA_WIDTH-1:0] hold2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold1_q <= '0;
      hold2_q <= '0;
    end else begin
      if (rv1_q) begin
        hold1_q <= rdata_s;
      end
      if (rv2_q) begin
        hold2_q <= rdata_s;
      end
    end
  end

  assign s1_readdata      = rv1_q ? rdata_s : hold1_q;
  assign s2_readdata      = rv2_q ? rdata_s : hold2_q;
  assign s1_readdatavalid = rv1_q;
  assign s2_readdatavalid = rv2_q;
`endif

endmodule

// File: tb/tb_mynios2_onchip_ram_dp.sv
// Scoreboard bench for mynios2_onchip_ram_dp: the driver predicts grants and
// read results from a word-array model and queues the expected returns; a
// separate monitor matches them against readdatavalid/readdata.
`timescale 1ns/1ps
module tb_mynios2_onchip_ram_dp;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1000;
  localparam int unsigned AW    = 10;
`ifdef MYNIOS2_ONCHIP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    bit          cs;
    bit          rd;
    bit          wr;
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
  } req_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [31:0] s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid;
  logic        s1_waitrequest, s2_waitrequest;

  req_t cur [2];
  exp_t q0 [$];
  exp_t q1 [$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last [2];
  bit ptr_s2 = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mynios2_onchip_ram_dp #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .INIT_FILE  ("")
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s1_address       (cur[0].a),
    .s1_byteenable    (cur[0].be),
    .s1_chipselect    (cur[0].cs),
    .s1_read          (cur[0].rd),
    .s1_write         (cur[0].wr),
    .s1_writedata     (cur[0].d),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .s1_waitrequest   (s1_waitrequest),
    .s2_address       (cur[1].a),
    .s2_byteenable    (cur[1].be),
    .s2_chipselect    (cur[1].cs),
    .s2_read          (cur[1].rd),
    .s2_write         (cur[1].wr),
    .s2_writedata     (cur[1].d),
    .s2_readdata      (s2_readdata),
    .s2_readdatavalid (s2_readdatavalid),
    .s2_waitrequest   (s2_waitrequest)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %08h expected %08h", name, cyc, act, expv);
    end
  endtask

  function automatic req_t idle_req();
    req_t r;
    r.cs = 1'b0; r.rd = 1'b0; r.wr = 1'b0;
    r.a = '0; r.be = '0; r.d = '0;
    return r;
  endfunction

  function automatic bit has_req(input req_t r);
    return r.cs && (r.rd || r.wr);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int unsigned k = $urandom_range(0, 9);
    int unsigned s = $urandom_range(0, 9);
    r = idle_req();
    if (k == 2) begin
      r.rd = 1'b1;                       // read without chipselect
    end else if (k >= 3) begin
      r.cs = 1'b1;
      if (k <= 5) r.rd = 1'b1;
      else if (k <= 8) r.wr = 1'b1;
      else begin r.rd = 1'b1; r.wr = 1'b1; end
    end
    if (s < 7)      r.a = 10'($urandom_range(0, 15));
    else if (s < 9) r.a = 10'($urandom_range(0, DEPTH - 1));
    else            r.a = 10'($urandom_range(996, 1023));
    r.be = 4'($urandom);
    r.d  = $urandom;
    return r;
  endfunction

  // Model of one accepted access.
  task automatic accept(input int p);
    req_t r = cur[p];
    exp_t e;
    if (r.wr) begin
      if (int'(r.a) < DEPTH)
        for (int b = 0; b < 4; b++)
          if (r.be[b]) ref_mem[r.a][8*b +: 8] = r.d[8*b +: 8];
    end else begin
      e.due  = cyc + LAT;
      e.data = (int'(r.a) < DEPTH) ? ref_mem[r.a] : 32'h0;
      if (p == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic flush_model();
    q0.delete();
    q1.delete();
    ptr_s2 = 1'b0;
  endtask

  // One clock cycle: predict grants, check waitrequest, update model.
  task automatic step(input bit rst_after, output bit g1, output bit g2);
    bit r1, r2;
    @(negedge clk);
    g1 = 1'b0;
    g2 = 1'b0;
    if (!reset_n) begin
      chk("waitreq1_in_reset", {31'b0, s1_waitrequest}, 32'd1);
      chk("waitreq2_in_reset", {31'b0, s2_waitrequest}, 32'd1);
    end else begin
      r1 = has_req(cur[0]);
      r2 = has_req(cur[1]);
      if (r1 && r2) begin
        g1 = !ptr_s2;
        g2 = ptr_s2;
        ptr_s2 = !ptr_s2;
      end else begin
        g1 = r1;
        g2 = r2;
      end
      chk("waitreq1", {31'b0, s1_waitrequest}, {31'b0, r1 && !g1});
      chk("waitreq2", {31'b0, s2_waitrequest}, {31'b0, r2 && !g2});
      if (g1) accept(0);
      if (g2) accept(1);
    end
    if (rst_after) begin
      #2;
      reset_n = 1'b0;
      flush_model();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int p, input bit rd, input bit wr, input logic [9:0] a,
                    input logic [3:0] be, input logic [31:0] d);
    bit g1, g2;
    req_t r;
    r.cs = 1'b1; r.rd = rd; r.wr = wr; r.a = a; r.be = be; r.d = d;
    cur[p]     = r;
    cur[1 - p] = idle_req();
    step(1'b0, g1, g2);
    cur[p] = idle_req();
  endtask

  task automatic do_reset(input int n);
    bit g1, g2;
    cur[0] = idle_req();
    cur[1] = idle_req();
    reset_n = 1'b0;
    flush_model();
    repeat (n) step(1'b0, g1, g2);
    reset_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    bit g1, g2;
    cur[0] = idle_req();
    cur[1] = idle_req();
    repeat (n) step(1'b0, g1, g2);
  endtask

  task automatic mon_port(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    bit ev;
    if (!reset_n) begin
      chk(p == 0 ? "rdvalid1_in_reset" : "rdvalid2_in_reset", {31'b0, v}, 32'd0);
      chk(p == 0 ? "rdata1_in_reset" : "rdata2_in_reset", d, 32'd0);
      last[p] = 32'h0;
    end else begin
      if (p == 0) ev = (q0.size() > 0) && (q0[0].due == cyc);
      else        ev = (q1.size() > 0) && (q1[0].due == cyc);
      chk(p == 0 ? "rdvalid1" : "rdvalid2", {31'b0, v}, {31'b0, ev});
      if (ev) begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        last[p] = e.data;
      end
      chk(p == 0 ? "rdata1" : "rdata2", d, last[p]);
    end
  endtask

  initial begin
    last[0] = 32'h0;
    last[1] = 32'h0;
    forever begin
      @(negedge clk);
      mon_port(0, s1_readdatavalid, s1_readdata);
      mon_port(1, s2_readdatavalid, s2_readdata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g1, g2;
    cur[0] = idle_req();
    cur[1] = idle_req();

    // Reset state, with requests presented during reset.
    cur[0].cs = 1'b1; cur[0].rd = 1'b1;
    cur[1].cs = 1'b1; cur[1].wr = 1'b1;
    repeat (3) step(1'b0, g1, g2);
    cur[0] = idle_req();
    cur[1] = idle_req();
    reset_n = 1'b1;

    // Fill the whole array so every in-range read has a known value.
    for (int a = 0; a < int'(DEPTH); a++) op(0, 1'b0, 1'b1, 10'(a), 4'hF, $urandom);

    // Single-port write then read.
    op(0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    op(0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    // Byte enables: expect 11BB33DD.
    op(0, 1'b0, 1'b1, 10'd7, 4'hF, 32'h11223344);
    op(0, 1'b0, 1'b1, 10'd7, 4'h5, 32'hAABBCCDD);
    op(0, 1'b1, 1'b0, 10'd7, 4'h0, 32'h0);
    // Out-of-range write dropped, out-of-range read returns 0.
    op(0, 1'b0, 1'b1, 10'd1000, 4'hF, 32'h12345678);
    op(0, 1'b1, 1'b0, 10'd1000, 4'h0, 32'h0);
    op(0, 1'b1, 1'b0, 10'd999, 4'h0, 32'h0);
    // Cross-port coherence.
    op(1, 1'b0, 1'b1, 10'd3, 4'hF, 32'hCAFEF00D);
    op(0, 1'b1, 1'b0, 10'd3, 4'h0, 32'h0);
    // Read+write together behaves as a write only.
    op(1, 1'b1, 1'b1, 10'd9, 4'hF, 32'h0BADCAFE);
    op(1, 1'b1, 1'b0, 10'd9, 4'h0, 32'h0);
    idle_cycles(LAT + 1);

    // Contention right after reset: grants alternate s1, s2, s1, s2.
    do_reset(2);
    cur[0].cs = 1'b1; cur[0].rd = 1'b1; cur[0].a = 10'd1;
    cur[1].cs = 1'b1; cur[1].rd = 1'b1; cur[1].a = 10'd1;
    repeat (4) step(1'b0, g1, g2);
    idle_cycles(LAT + 1);

    // Reset asserted while an s2 read is in flight.
    cur[0] = idle_req();
    cur[1] = idle_req();
    cur[1].cs = 1'b1; cur[1].rd = 1'b1; cur[1].a = 10'd5;
    step(1'b1, g1, g2);
    cur[1] = idle_req();
    repeat (3) step(1'b0, g1, g2);
    reset_n = 1'b1;
    idle_cycles(2);
    op(1, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    op(1, 1'b1, 1'b0, 10'd7, 4'h0, 32'h0);

    // Randomized two-port traffic; a master holds its request until granted.
    cur[0] = rand_req();
    cur[1] = rand_req();
    for (int n = 0; n < 3000; n++) begin
      step(1'b0, g1, g2);
      if (g1 || !has_req(cur[0])) cur[0] = rand_req();
      if (g2 || !has_req(cur[1])) cur[1] = rand_req();
    end

    idle_cycles(LAT + 2);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
